// File: rtl/uart_bus_bridge_target.sv
// uart_bus_bridge_target: responder end of the UART bus bridge. Parses command
// frames from the UART RX byte stream, replays each as one local bus
// transaction (as bus master) and returns a status/response frame on UART TX.
// Build option: define UART_BRIDGE_CHECKSUM_EN for the XOR checksum byte on
// request and response frames.
module uart_bus_bridge_target #(
  parameter int ADDR_WIDTH  = 16,
  parameter int GAP_TIMEOUT = 50000,
  parameter int BUS_TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [7:0]            bus_wdata,
  input  logic                  bus_ack,
  input  logic [7:0]            bus_rdata,
  output logic                  busy,
  output logic                  frame_err
);

  localparam int GW = $clog2(GAP_TIMEOUT + 1);
  localparam int BW = $clog2(BUS_TIMEOUT + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_TIMEOUT - 1);
  localparam logic [BW-1:0] BUS_LAST = BW'(BUS_TIMEOUT - 1);

  localparam logic [7:0] CMD_WR = 8'h57;
  localparam logic [7:0] CMD_RD = 8'h52;
  localparam logic [7:0] ST_OK  = 8'hAA;
  localparam logic [7:0] ST_ERR = 8'hEE;

`ifdef UART_BRIDGE_CHECKSUM_EN
  typedef enum logic [3:0] {
    S_IDLE, S_ADDR_H, S_ADDR_L, S_DATA, S_CHK, S_BUS,
    S_RESP_STAT, S_RESP_DATA, S_RESP_SUM
  } state_t;
  localparam state_t S_REQ_END = S_CHK;
`else
  typedef enum logic [3:0] {
    S_IDLE, S_ADDR_H, S_ADDR_L, S_DATA, S_BUS,
    S_RESP_STAT, S_RESP_DATA
  } state_t;
  localparam state_t S_REQ_END = S_BUS;
`endif

  state_t          state_q, state_d;
  logic            wr_q, wr_d;
  logic [15:0]     addr_q, addr_d;
  logic [7:0]      wdata_q, wdata_d;
  logic [7:0]      rdata_q, rdata_d;
  logic            ok_q, ok_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [BW-1:0]   bto_q, bto_d;
  logic            bus_req_q, bus_req_d;
  logic            tx_valid_q, tx_valid_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            frame_err_q, frame_err_d;
`ifdef UART_BRIDGE_CHECKSUM_EN
  logic [7:0]      sum_q, sum_d;
`endif
  logic            collecting, responding, tx_done;

  // Next-state and next-output computation for the frame/bus/response FSM.
  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    ok_d        = ok_q;
    gap_d       = '0;
    bto_d       = '0;
    bus_req_d   = bus_req_q;
    tx_valid_d  = tx_valid_q;
    tx_data_d   = tx_data_q;
    frame_err_d = 1'b0;
`ifdef UART_BRIDGE_CHECKSUM_EN
    sum_d       = sum_q;
`endif
    collecting  = 1'b0;
    responding  = 1'b0;
    tx_done     = tx_valid_q && tx_ready;

    case (state_q)
      S_IDLE: begin
        if (rx_valid && (rx_data == CMD_WR || rx_data == CMD_RD)) begin
          wr_d    = (rx_data == CMD_WR);
          state_d = S_ADDR_H;
        end
      end
      S_ADDR_H: begin
        collecting = 1'b1;
        if (rx_valid) begin
          addr_d[15:8] = rx_data;
          state_d      = S_ADDR_L;
        end
      end
      S_ADDR_L: begin
        collecting = 1'b1;
        if (rx_valid) begin
          addr_d[7:0] = rx_data;
          state_d     = wr_q ? S_DATA : S_REQ_END;
        end
      end
      S_DATA: begin
        collecting = 1'b1;
        if (rx_valid) begin
          wdata_d = rx_data;
          state_d = S_REQ_END;
        end
      end
`ifdef UART_BRIDGE_CHECKSUM_EN
      S_CHK: begin
        collecting = 1'b1;
        if (rx_valid) begin
          if (rx_data == sum_q) begin
            state_d = S_BUS;
          end else begin
            ok_d        = 1'b0;
            frame_err_d = 1'b1;
            tx_valid_d  = 1'b1;
            tx_data_d   = ST_ERR;
            state_d     = S_RESP_STAT;
          end
        end
      end
`endif
      S_BUS: begin
        responding = 1'b1;
        // First BUS cycle only raises the request; ack is honoured once req is high.
        if (!bus_req_q) begin
          bus_req_d = 1'b1;
        end else if (bus_ack) begin
          bus_req_d  = 1'b0;
          rdata_d    = bus_rdata;
          ok_d       = 1'b1;
          tx_valid_d = 1'b1;
          tx_data_d  = ST_OK;
          state_d    = S_RESP_STAT;
        end else if (bto_q == BUS_LAST) begin
          bus_req_d   = 1'b0;
          ok_d        = 1'b0;
          frame_err_d = 1'b1;
          tx_valid_d  = 1'b1;
          tx_data_d   = ST_ERR;
          state_d     = S_RESP_STAT;
        end else begin
          bto_d = bto_q + BW'(1);
        end
      end
      S_RESP_STAT: begin
        responding = 1'b1;
        if (tx_done) begin
          if (ok_q && !wr_q) begin
            tx_data_d = rdata_q;
            state_d   = S_RESP_DATA;
`ifdef UART_BRIDGE_CHECKSUM_EN
          end else if (ok_q) begin
            tx_data_d = ST_OK;
            state_d   = S_RESP_SUM;
`endif
          end else begin
            tx_valid_d = 1'b0;
            state_d    = S_IDLE;
          end
        end
      end
      S_RESP_DATA: begin
        responding = 1'b1;
        if (tx_done) begin
`ifdef UART_BRIDGE_CHECKSUM_EN
          tx_data_d = ST_OK ^ rdata_q;
          state_d   = S_RESP_SUM;
`else
          tx_valid_d = 1'b0;
          state_d    = S_IDLE;
`endif
        end
      end
`ifdef UART_BRIDGE_CHECKSUM_EN
      S_RESP_SUM: begin
        responding = 1'b1;
        if (tx_done) begin
          tx_valid_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

`ifdef UART_BRIDGE_CHECKSUM_EN
    if (state_q == S_IDLE) begin
      sum_d = rx_data;
    end else if (collecting && rx_valid) begin
      sum_d = sum_q ^ rx_data;
    end
`endif

    // Inter-byte gap supervision; any received byte restarts the count.
    if (collecting && !rx_valid) begin
      if (gap_q == GAP_LAST) begin
        state_d     = S_IDLE;
        frame_err_d = 1'b1;
      end else begin
        gap_d = gap_q + GW'(1);
      end
    end

    if (responding && rx_valid) begin
      frame_err_d = 1'b1;
    end
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      ok_q        <= 1'b0;
      gap_q       <= '0;
      bto_q       <= '0;
      bus_req_q   <= 1'b0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= '0;
      frame_err_q <= 1'b0;
`ifdef UART_BRIDGE_CHECKSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      ok_q        <= ok_d;
      gap_q       <= gap_d;
      bto_q       <= bto_d;
      bus_req_q   <= bus_req_d;
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
      frame_err_q <= frame_err_d;
`ifdef UART_BRIDGE_CHECKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = wr_q;
  assign bus_addr  = ADDR_WIDTH'(addr_q);
  assign bus_wdata = wdata_q;
  assign busy      = (state_q != S_IDLE);
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_bus_bridge_target.sv
// tb_uart_bus_bridge_target: randomized frames against a frame-level model of
// the bridge (expected bus access, response bytes, error pulses, latency).
`timescale 1ns/1ps
module tb_uart_bus_bridge_target;

  localparam int GAP_TO = 40;
  localparam int BUS_TO = 32;
  localparam int NEVER  = 1 << 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        bus_req;
  logic        bus_we;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic        bus_ack = 1'b0;
  logic [7:0]  bus_rdata = '0;
  logic        busy;
  logic        frame_err;

  uart_bus_bridge_target #(
    .ADDR_WIDTH (16),
    .GAP_TIMEOUT(GAP_TO),
    .BUS_TIMEOUT(BUS_TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .bus_req  (bus_req),
    .bus_we   (bus_we),
    .bus_addr (bus_addr),
    .bus_wdata(bus_wdata),
    .bus_ack  (bus_ack),
    .bus_rdata(bus_rdata),
    .busy     (busy),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Frame-level model state for the frame in flight
  bit          exp_we;
  logic [15:0] exp_addr;
  logic [7:0]  exp_wdata;
  bit          exp_bus;
  logic [7:0]  exp_tx[$];
  int          tx_idx;
  logic [7:0]  tx_log[$];
  bit          cmp_en = 1'b0;
  bit          pend = 1'b0;
  int          ferr_cnt = 0;
  bit          hold_ready = 1'b0;

  // Bus slave state
  int          slave_delay = NEVER;
  logic [7:0]  slave_rdata = '0;
  int          s_cnt = 0;
  bit          s_acked = 1'b0;
  bit          prev_req = 1'b0;
  int          req_rises = 0;
  int          req_len = 0;
  int          last_req_len = 0;
  int          txn_cnt = 0;
  logic        txn_we = 1'b0;
  logic [15:0] txn_addr = '0;
  logic [7:0]  txn_wdata = '0;

  // Expected response bytes derived from the frame outcome
  function automatic void build_exp(input bit wr, input logic [7:0] rd, input bit bus_ok, input bit chk_ok);
    exp_tx.delete();
    if (!chk_ok || !bus_ok) begin
      exp_tx.push_back(8'hEE);
    end else begin
      exp_tx.push_back(8'hAA);
      if (!wr) exp_tx.push_back(rd);
`ifdef UART_BRIDGE_CHECKSUM_EN
      exp_tx.push_back(wr ? 8'hAA : (8'hAA ^ rd));
`endif
    end
  endfunction

  function automatic logic [31:0] logged(input int i);
    if (i < tx_log.size()) return 32'(tx_log[i]);
    return 32'hFFFF_FFFF;
  endfunction

  // Transmitter: random backpressure, or held off on request
  initial forever begin
    @(posedge clk); #1;
    tx_ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  // Bus slave: ack after slave_delay request cycles, stray acks while idle
  initial forever begin
    @(posedge clk); #1;
    if (bus_req) begin
      if (!prev_req) req_rises++;
      req_len++;
      if (!s_acked && s_cnt == slave_delay) begin
        bus_ack   = 1'b1;
        bus_rdata = slave_rdata;
        s_acked   = 1'b1;
        txn_cnt++;
        txn_we    = bus_we;
        txn_addr  = bus_addr;
        txn_wdata = bus_wdata;
      end else begin
        bus_ack = 1'b0;
      end
      s_cnt++;
    end else begin
      if (prev_req) last_req_len = req_len;
      req_len   = 0;
      s_cnt     = 0;
      s_acked   = 1'b0;
      bus_ack   = ($urandom_range(0, 7) == 0);
      bus_rdata = 8'($urandom);
    end
    prev_req = bus_req;
  end

  // Per-cycle comparison of TX and bus outputs against the model
  initial forever begin
    @(negedge clk);
    if (frame_err) ferr_cnt++;
    if (!cmp_en || rst) begin
      pend = 1'b0;
    end else begin
      if (tx_valid) begin
        if (tx_idx < exp_tx.size()) check("tx_data", 32'(tx_data), 32'(exp_tx[tx_idx]));
        else check("tx_unexpected", 32'(tx_valid), 32'h0);
        if (tx_ready) begin
          tx_log.push_back(tx_data);
          tx_idx++;
        end
      end else if (pend) begin
        check("tx_valid_held", 32'(tx_valid), 32'h1);
      end
      pend = tx_valid && !tx_ready;
      if (bus_req) begin
        check("bus_busy", 32'(busy), 32'h1);
        check("bus_allowed", 32'(bus_req), 32'(exp_bus));
        if (exp_bus) begin
          check("bus_we", 32'(bus_we), 32'(exp_we));
          check("bus_addr", 32'(bus_addr), 32'(exp_addr));
          if (exp_we) check("bus_wdata", 32'(bus_wdata), 32'(exp_wdata));
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) @(posedge clk);
    @(posedge clk); #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 4000) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, 32'(busy), 32'h0);
  endtask

  task automatic set_quiet_model();
    exp_bus = 1'b0;
    exp_tx.delete();
    tx_idx = 0;
    tx_log.delete();
  endtask

  task automatic do_frame(input bit wr, input logic [15:0] addr, input logic [7:0] data,
                          input logic [7:0] rd, input int delay, input bit chk_ok,
                          input bit inject, input int hold);
    logic [7:0] bytes[$];
    logic [7:0] x;
    int f0, r0, t0, nerr, n;
    bit bus_ok;
    bus_ok = (delay != NEVER);
    f0 = ferr_cnt;
    r0 = req_rises;
    t0 = txn_cnt;
    slave_delay = delay;
    slave_rdata = rd;
    exp_we    = wr;
    exp_addr  = addr;
    exp_wdata = data;
    exp_bus   = chk_ok;
    tx_idx    = 0;
    tx_log.delete();
    build_exp(wr, rd, bus_ok, chk_ok);
    nerr = (chk_ok && bus_ok) ? 0 : 1;
    if (inject) nerr++;
    bytes.push_back(wr ? 8'h57 : 8'h52);
    bytes.push_back(addr[15:8]);
    bytes.push_back(addr[7:0]);
    if (wr) bytes.push_back(data);
`ifdef UART_BRIDGE_CHECKSUM_EN
    x = '0;
    foreach (bytes[i]) x = x ^ bytes[i];
    bytes.push_back(chk_ok ? x : ((x != 8'h00) ? 8'h00 : 8'hFF));
`else
    x = '0;
`endif
    hold_ready = (hold > 0);
    foreach (bytes[i]) send_byte(bytes[i], int'($urandom_range(0, 4)));
    if (chk_ok) begin
      check("latency_c1", 32'(bus_req), 32'h0);
      @(posedge clk); #1;
      check("latency_c2", 32'(bus_req), 32'h1);
    end
    if (inject) send_byte(8'h99, 0);
    if (hold > 0) begin
      n = 0;
      while (!tx_valid && n < 4000) begin
        @(posedge clk); #1;
        n++;
      end
      repeat (hold) @(posedge clk);
      #1;
      check("hold_valid", 32'(tx_valid), 32'h1);
      check("hold_data", 32'(tx_data), 32'(exp_tx[0]));
      hold_ready = 1'b0;
    end
    wait_idle("frame_done");
    check("tx_count", 32'(tx_idx), 32'(exp_tx.size()));
    check("frame_err_count", 32'(ferr_cnt - f0), 32'(nerr));
    check("bus_access_count", 32'(req_rises - r0), chk_ok ? 32'h1 : 32'h0);
    if (chk_ok && bus_ok) check("ack_count", 32'(txn_cnt - t0), 32'h1);
    if (chk_ok && !bus_ok) check("req_len", 32'(last_req_len), 32'(BUS_TO));
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int f0, r0;
    bit wr, c;
    int d;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_valid", 32'(tx_valid), 32'h0);
    check("rst_tx_data", 32'(tx_data), 32'h0);
    check("rst_bus_req", 32'(bus_req), 32'h0);
    check("rst_bus_we", 32'(bus_we), 32'h0);
    check("rst_bus_addr", 32'(bus_addr), 32'h0);
    check("rst_bus_wdata", 32'(bus_wdata), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_frame_err", 32'(frame_err), 32'h0);
    rst = 1'b0;
    cmp_en = 1'b1;
    @(posedge clk); #1;

    // Write 57 00 10 A5, ack after 3 request cycles
    do_frame(1'b1, 16'h0010, 8'hA5, 8'h00, 3, 1'b1, 1'b0, 0);
    check("pin_wr_we", 32'(txn_we), 32'h1);
    check("pin_wr_addr", 32'(txn_addr), 32'h0010);
    check("pin_wr_wdata", 32'(txn_wdata), 32'hA5);
    check("pin_wr_stat", logged(0), 32'hAA);
`ifdef UART_BRIDGE_CHECKSUM_EN
    check("pin_wr_sum", logged(1), 32'hAA);
`endif

    // Read 52 00 10, slave returns A5, transmitter held off 20 cycles
    do_frame(1'b0, 16'h0010, 8'h00, 8'hA5, 2, 1'b1, 1'b0, 20);
    check("pin_rd_we", 32'(txn_we), 32'h0);
    check("pin_rd_stat", logged(0), 32'hAA);
    check("pin_rd_data", logged(1), 32'hA5);
`ifdef UART_BRIDGE_CHECKSUM_EN
    check("pin_rd_sum", logged(2), 32'h0F);
`endif

    // Read with no ack: timeout response
    do_frame(1'b0, 16'h1234, 8'h00, 8'h5A, NEVER, 1'b1, 1'b0, 0);
    check("pin_to_stat", logged(0), 32'hEE);

    // Partial frame then silence past the gap limit
    set_quiet_model();
    f0 = ferr_cnt;
    r0 = req_rises;
    send_byte(8'h57, 0);
    send_byte(8'h00, 0);
    repeat (GAP_TO + 1) @(posedge clk);
    #1;
    check("gap_frame_err", 32'(ferr_cnt - f0), 32'h1);
    check("gap_busy", 32'(busy), 32'h0);
    check("gap_no_req", 32'(req_rises - r0), 32'h0);
    do_frame(1'b1, 16'hBEEF, 8'h3C, 8'h00, 1, 1'b1, 1'b0, 0);

    // Stray non-command byte while idle
    set_quiet_model();
    f0 = ferr_cnt;
    send_byte(8'h33, 0);
    check("stray_busy", 32'(busy), 32'h0);
    @(posedge clk); #1;
    check("stray_frame_err", 32'(ferr_cnt - f0), 32'h0);

    // Extra byte while the bus access is pending
    do_frame(1'b0, 16'h0042, 8'h00, 8'h77, 8, 1'b1, 1'b1, 0);

    // Reset in the middle of a bus access
    exp_we   = 1'b0;
    exp_addr = 16'h0020;
    exp_bus  = 1'b1;
    exp_tx.delete();
    tx_idx = 0;
    slave_delay = NEVER;
    send_byte(8'h52, 0);
    send_byte(8'h00, 0);
    send_byte(8'h20, 0);
    repeat (4) @(posedge clk);
    #1;
    check("rst_mid_req_pre", 32'(bus_req), 32'h1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_bus_req", 32'(bus_req), 32'h0);
    check("rst_mid_tx_valid", 32'(tx_valid), 32'h0);
    check("rst_mid_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    do_frame(1'b1, 16'h0055, 8'hC3, 8'h00, 0, 1'b1, 1'b0, 0);

`ifdef UART_BRIDGE_CHECKSUM_EN
    // Checksum of 57 00 10 A5 is E2; a CHK byte of 00 must be refused
    do_frame(1'b1, 16'h0010, 8'hA5, 8'h00, 3, 1'b0, 1'b0, 0);
    check("pin_chk_bad_stat", logged(0), 32'hEE);
`endif

    for (int k = 0; k < 40; k++) begin
      wr = 1'($urandom_range(0, 1));
      d  = ($urandom_range(0, 7) == 0) ? NEVER : int'($urandom_range(0, 6));
      c  = 1'b1;
`ifdef UART_BRIDGE_CHECKSUM_EN
      c  = ($urandom_range(0, 5) != 0);
`endif
      do_frame(wr, 16'($urandom), 8'($urandom), 8'($urandom), d, c, 1'b0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
